// File: rtl/inst_fetcher_pkg.sv
// Shared fetch/decode definitions: word width, fetch FSM encoding, queue entry layout.
package inst_fetcher_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DISCARD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t inst;
    word_t pc;
  } qentry_t;

  function automatic word_t word_align(input word_t a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Instruction FIFO between fetch and decode; head entry is presented combinationally.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WORD_W-1:0]        push_inst,
  input  logic [WORD_W-1:0]        push_pc,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [WORD_W-1:0]        head_inst,
  output logic [WORD_W-1:0]        head_pc
);

  localparam int unsigned AW = $clog2(DEPTH);

  qentry_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= '{inst: push_inst, pc: push_pc};
  end

  // Empty queue presents zeros so the decoder never sees stale words.
  assign head_valid = (count != '0);
  assign head_inst  = head_valid ? mem[rd_ptr].inst : '0;
  assign head_pc    = head_valid ? mem[rd_ptr].pc   : '0;

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch: single-outstanding memory request FSM, fetch PC, redirect handling.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  word_t         fetch_pc, fetch_pc_nxt;
  logic          req_nxt;
  word_t         addr_nxt;
  logic          q_push, q_pop, q_flush;
  logic [CW-1:0] q_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      mem_req  <= req_nxt;
      mem_addr <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = mem_req;
    addr_nxt     = mem_addr;
    q_push       = 1'b0;
    q_pop        = 1'b0;
    q_flush      = 1'b0;
    if (rdy) begin
      q_flush = flush;
      q_pop   = inst_valid && inst_ready && !flush;
      if (flush) fetch_pc_nxt = word_align(flush_pc);
      case (state)
        IDLE: begin
          if (!flush && (q_count < CW'(QUEUE_DEPTH))) begin
            state_nxt = WAIT_MEM;
            req_nxt   = 1'b1;
            addr_nxt  = fetch_pc;
          end
        end
        WAIT_MEM: begin
          if (mem_done) begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            if (!flush) begin
              q_push       = 1'b1;
              fetch_pc_nxt = fetch_pc + 32'd4;
            end
          end else if (flush) begin
            state_nxt = DISCARD;
          end
        end
        DISCARD: begin
          if (mem_done) begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      endcase
    end
  end

  inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_inst  (mem_data),
    .push_pc    (fetch_pc),
    .pop        (q_pop),
    .flush      (q_flush),
    .count      (q_count),
    .head_valid (inst_valid),
    .head_inst  (inst_out),
    .head_pc    (inst_pc)
  );

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher against a transaction-level fetch/queue model.
module tb_inst_fetcher;

  localparam int unsigned QD  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, rdy, mem_req, mem_done, inst_valid, inst_ready, flush;
  logic [31:0] mem_addr, mem_data, inst_out, inst_pc, flush_pc;

  inst_fetcher #(.QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_done   (mem_done),
    .mem_data   (mem_data),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .flush      (flush),
    .flush_pc   (flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  // Model: in-order queue of fetched words, fetch address, and the one outstanding request.
  ent_t        mq[$];
  ent_t        ent;
  logic [31:0] m_pc, m_addr;
  bit          m_out, m_live, just_rst, seen_first, pend, pop_m;
  int          sz, lat;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_flush_pc();
    case ($urandom % 4)
      0:       return 32'h100;
      1:       return 32'hFFFFFFF0 | ($urandom % 16);
      2:       return $urandom;
      default: return 32'hFFFFFFFC;
    endcase
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; mem_done = 1'b0; mem_data = '0;
    inst_ready = 1'b1; flush = 1'b0; flush_pc = '0;
    mq.delete(); m_pc = RPC; m_addr = RPC; m_out = 0; m_live = 0;
    just_rst = 0; seen_first = 0; pend = 0; lat = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("inst_valid", inst_valid, {31'b0, mq.size() > 0});
        if (mq.size() > 0) begin
          check("inst_pc", inst_pc, mq[0].pc);
          check("inst_out", inst_out, mq[0].data);
        end
        check("mem_req", mem_req, {31'b0, m_out});
        if (m_out || just_rst) check("mem_addr", mem_addr, m_addr);
        if (just_rst) begin
          check("rst_inst_out", inst_out, 32'h0);
          check("rst_inst_pc", inst_pc, 32'h0);
        end
        if (c < 40 && !seen_first && inst_valid) begin
          seen_first = 1;
          check("first_pc", inst_pc, RPC);
          check("first_inst", inst_out, 32'h00000013);
        end
      end

      if (m_out && !pend) begin
        pend = 1;
        lat  = (c < 40) ? 3 : int'($urandom_range(1, 4));
      end

      rst = (c < 2) || (c >= 100 && ($urandom % 400 == 0));
      if (c < 40) begin
        rdy = 1; inst_ready = 1; flush = 0;
      end else if (c < 80) begin
        rdy = 1; inst_ready = 0; flush = 0;
      end else if (c < 100) begin
        rdy = 1; inst_ready = 1; flush = 0;
      end else begin
        rdy        = ((c % 60) >= 20 && (c % 60) < 25) ? 1'b0 : ($urandom % 8 != 0);
        inst_ready = ($urandom % 3 != 0);
        flush      = ($urandom % 12 == 0);
      end
      flush_pc = pick_flush_pc();
      mem_done = pend && rdy && (lat == 1) && !rst;
      mem_data = mem_done ? ((c < 40) ? 32'h00000013 : $urandom) : $urandom;

      @(posedge clk);
      if (rst) begin
        mq.delete(); m_pc = RPC; m_addr = RPC; m_out = 0; m_live = 0;
        just_rst = 1; pend = 0;
      end else begin
        just_rst = 0;
        if (rdy) begin
          sz    = mq.size();
          pop_m = (sz > 0) && inst_ready && !flush;
          if (flush) begin
            mq.delete();
            m_pc = {flush_pc[31:2], 2'b00};
            if (m_out) begin
              if (mem_done) m_out = 0;
              else          m_live = 0;
            end
          end else begin
            if (pop_m) void'(mq.pop_front());
            if (m_out) begin
              if (mem_done) begin
                m_out = 0;
                if (m_live) begin
                  ent.pc = m_pc; ent.data = mem_data;
                  mq.push_back(ent);
                  m_pc = m_pc + 32'd4;
                end
              end
            end else if (sz < int'(QD)) begin
              m_out = 1; m_live = 1; m_addr = m_pc;
            end
          end
          if (pend) begin
            if (mem_done) pend = 0;
            else          lat--;
          end
        end
      end
    end

    if (!seen_first) check("first_fetch_seen", 32'h0, 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, instruction queue entries; SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0, fetch PC loaded on reset.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global enable; when low, all state SHALL hold.
REQ-006 mem_req  out  1  fetch request to the memory controller.
REQ-007 mem_addr  out  32  byte address of the requested instruction word.
REQ-008 mem_done  in  1  one-cycle pulse; mem_data valid; SHALL only assert while rdy is high.
REQ-009 mem_data  in  32  fetched instruction word.
REQ-010 inst_valid  out  1  queue head valid toward the decoder.
REQ-011 inst_out  out  32  queue-head instruction; feeds decoder op_in.
REQ-012 inst_pc  out  32  PC of the queue-head instruction.
REQ-013 inst_ready  in  1  consumer accepts the head this cycle.
REQ-014 flush  in  1  redirect request; mispredict or jump resolution.
REQ-015 flush_pc  in  32  redirect target; bits [1:0] SHALL be treated as zero.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_MEM, and DISCARD.
REQ-017 IDLE -> WAIT_MEM SHALL occur when rdy, !flush, and queue count < QUEUE_DEPTH; mem_req=1, mem_addr=fetch_pc are registered that edge.
REQ-018 In WAIT_MEM and DISCARD, mem_req SHALL stay 1 with mem_addr stable until the mem_done cycle, and SHALL be 0 the cycle after.
REQ-019 At most one request SHALL be outstanding at any time.
REQ-020 WAIT_MEM + mem_done + !flush: push {mem_data, fetch_pc}; fetch_pc += 4 (mod 2^32, wraps 32'hFFFFFFFC -> 0); -> IDLE.
REQ-021 Latency: an instruction pushed at edge N SHALL be visible with inst_valid=1 after edge N when the queue was empty.
REQ-022 inst_valid SHALL equal queue non-empty; inst_out/inst_pc SHALL be the head entry.
REQ-023 Pop SHALL occur when inst_valid && inst_ready && !flush.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged; the issue rule in REQ-017 guarantees a push never meets a full queue.
REQ-025 flush (rdy high) SHALL take priority over push, pop, and issue: queue emptied, fetch_pc=flush_pc, inst_valid=0 next cycle.
REQ-026 flush in WAIT_MEM without mem_done -> DISCARD; flush with mem_done in the same cycle -> IDLE with the data dropped.
REQ-027 DISCARD + mem_done: the data SHALL be dropped, fetch_pc is unchanged, and the FSM goes to IDLE; flush in DISCARD SHALL update fetch_pc and stay in DISCARD.
REQ-028 flush in IDLE SHALL suppress issue that cycle; the first request to flush_pc SHALL issue the following cycle.

Reset
REQ-029 When rst=1 at an edge, the block SHALL set state=IDLE, fetch_pc=RESET_PC, queue empty, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0; rst overrides rdy.
REQ-030 rst asserted mid-request SHALL abandon it; the memory controller is reset by the same rst.

Structure
REQ-031 FSM state encodings and the 32-bit word width SHALL live in the shared definitions header used by the decoder.
REQ-032 The queue SHALL be the sub-module inst_queue (push/pop/flush, count, head output); inst_fetcher holds the FSM and PC.

Verification
REQ-033 Reset, then memory returns 32'h00000013 after 3 cycles with inst_ready=1 -> mem_addr sequence 0, 4, 8; inst_pc 0 first with inst_out 32'h00000013.
REQ-034 inst_ready=0, QUEUE_DEPTH=4 -> exactly 4 requests issued (0..C), then mem_req stays 0; releasing inst_ready pops in order 0, 4, 8, C.
REQ-035 flush=1 with flush_pc=32'h100 while WAIT_MEM for 32'h8, mem_done 2 cycles later -> data dropped, inst_valid=0, next mem_addr=32'h100.
REQ-036 flush and mem_done in the same cycle -> no push; next request addr = flush_pc.
REQ-037 rdy=0 for 5 cycles mid-stream -> all outputs frozen; resumes identically.
REQ-038 fetch_pc=32'hFFFFFFFC returns data -> next mem_addr=32'h0.
